// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the CDB arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cdb_arbiter_pkg;

    localparam int DATA_LEN = 32;
    localparam int ROB_LEN  = 4;
    localparam int ROB_ID_W = ROB_LEN + 1;

    localparam logic [ROB_ID_W-1:0] ZERO_ROB  = '0;
    localparam logic [DATA_LEN-1:0] ZERO_WORD = '0;
    localparam logic                TRUE      = 1'b1;
    localparam logic                FALSE     = 1'b0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LS  = 1'b1
    } src_e;

    // Round-robin pick: a lone requester wins; on a tie the source that did not win last time wins.
    function automatic src_e rr_pick(input logic alu_req, input logic ls_req, input src_e last);
        src_e pick;
        pick = SRC_ALU;
        if (alu_req && ls_req) begin
            pick = (last == SRC_ALU) ? SRC_LS : SRC_ALU;
        end else if (ls_req) begin
            pick = SRC_LS;
        end
        return pick;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result queue, DEPTH x {rob_id, result}, with head-of-queue visible combinationally.
// Latency: a pushed entry is at the head one edge later; pop and push may coincide.
// Backpressure: ready = count < DEPTH from the registered count; flush empties it and beats push/pop.
module cdb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_dat,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign ready    = (count_q < CW'(DEPTH));
    assign head_dat = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        do_push  = push && ready && !flush;
        do_pop   = pop && !empty && !flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Queue state registers; storage itself needs no reset since count gates visibility.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin share of the common data bus between the ALU and load/store result paths.
// Latency: 2 cycles input-to-broadcast (1 cycle from an empty queue when CDB_BYPASS_EN is defined).
// Backpressure: per-source ready drops when that queue is full; flush drops everything pending.
module cdb_arbiter #(
    parameter int DATA_LEN = 32,
    parameter int ROB_ID_W = 5,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                alu_valid,
    input  logic [ROB_ID_W-1:0] alu_rob_id,
    input  logic [DATA_LEN-1:0] alu_result,
    output logic                alu_ready,
    input  logic                ls_valid,
    input  logic [ROB_ID_W-1:0] ls_rob_id,
    input  logic [DATA_LEN-1:0] ls_result,
    output logic                ls_ready,
    output logic                cdb_valid,
    output logic [ROB_ID_W-1:0] cdb_rob_id,
    output logic [DATA_LEN-1:0] cdb_result,
    output logic                cdb_src
);

    import cdb_arbiter_pkg::*;

    localparam int EW = ROB_ID_W + DATA_LEN;

    logic [EW-1:0]       alu_head, ls_head, win_dat;
    logic                alu_empty, ls_empty;
    logic                alu_take, ls_take;
    logic                alu_req, ls_req;
    logic                alu_push, ls_push, alu_pop, ls_pop;
    logic                alu_byp, ls_byp;
    logic                grant_any;
    src_e                grant_src;

    logic                cdb_valid_q, cdb_valid_d;
    logic [ROB_ID_W-1:0] cdb_rob_id_q, cdb_rob_id_d;
    logic [DATA_LEN-1:0] cdb_result_q, cdb_result_d;
    logic                cdb_src_q, cdb_src_d;
    src_e                last_grant_q, last_grant_d;

    // A source offers a result only with a real tag, queue room and no flush in progress.
    assign alu_take = alu_valid && (alu_rob_id != '0) && alu_ready && !flush;
    assign ls_take  = ls_valid && (ls_rob_id != '0) && ls_ready && !flush;

`ifdef CDB_BYPASS_EN
    assign alu_req = !alu_empty || alu_take;
    assign ls_req  = !ls_empty || ls_take;
`else
    assign alu_req = !alu_empty;
    assign ls_req  = !ls_empty;
`endif

    // Arbitrate, then route the winner from its queue head or, from an empty queue, straight from the input.
    always_comb begin
        grant_any = !flush && (alu_req || ls_req);
        grant_src = rr_pick(alu_req, ls_req, last_grant_q);
        alu_byp   = grant_any && (grant_src == SRC_ALU) && alu_empty;
        ls_byp    = grant_any && (grant_src == SRC_LS) && ls_empty;
        alu_pop   = grant_any && (grant_src == SRC_ALU) && !alu_empty;
        ls_pop    = grant_any && (grant_src == SRC_LS) && !ls_empty;
        alu_push  = alu_take && !alu_byp;
        ls_push   = ls_take && !ls_byp;
        if (grant_src == SRC_ALU) begin
            win_dat = alu_byp ? {alu_rob_id, alu_result} : alu_head;
        end else begin
            win_dat = ls_byp ? {ls_rob_id, ls_result} : ls_head;
        end

        cdb_valid_d  = FALSE;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_result_d = cdb_result_q;
        cdb_src_d    = cdb_src_q;
        last_grant_d = last_grant_q;
        if (grant_any) begin
            cdb_valid_d  = TRUE;
            cdb_rob_id_d = win_dat[EW-1:DATA_LEN];
            cdb_result_d = win_dat[DATA_LEN-1:0];
            cdb_src_d    = grant_src;
            last_grant_d = grant_src;
        end
    end

    cdb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_alu_q (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (alu_push),
        .pop      (alu_pop),
        .push_dat ({alu_rob_id, alu_result}),
        .head_dat (alu_head),
        .empty    (alu_empty),
        .ready    (alu_ready)
    );

    cdb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_ls_q (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (ls_push),
        .pop      (ls_pop),
        .push_dat ({ls_rob_id, ls_result}),
        .head_dat (ls_head),
        .empty    (ls_empty),
        .ready    (ls_ready)
    );

    // Broadcast register and round-robin history; last_grant starts at LS so the ALU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q  <= FALSE;
            cdb_rob_id_q <= '0;
            cdb_result_q <= '0;
            cdb_src_q    <= SRC_ALU;
            last_grant_q <= SRC_LS;
        end else begin
            cdb_valid_q  <= cdb_valid_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_result_q <= cdb_result_d;
            cdb_src_q    <= cdb_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_rob_id = cdb_rob_id_q;
    assign cdb_result = cdb_result_q;
    assign cdb_src    = cdb_src_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the ALU result path (RS/EX) and the load/store result path (LSB).
- Each source gets a small per-source result queue. A round-robin grant selects one entry per cycle, and that entry is broadcast as a registered CDB word to the RS, LSB and ROB.
- Supplies backpressure so a producer holds issue when its queue is full.
- A rollback flush empties all queued results.

Parameters:
- DATA_LEN, 32, result width.
- ROB_ID_W, 5, ROB tag width (ROB_LEN+1); tag 0 = no producer / invalid.
- DEPTH, 2, entries per source queue (power of two, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  rollback; drop all pending results.
- alu_valid  in  1  ALU result present this cycle.
- alu_rob_id  in  ROB_ID_W  ALU result tag.
- alu_result  in  DATA_LEN  ALU result value.
- alu_ready  out  1  ALU queue can accept next cycle's result.
- ls_valid  in  1  load/store result present.
- ls_rob_id  in  ROB_ID_W  load/store tag.
- ls_result  in  DATA_LEN  load value.
- ls_ready  out  1  load/store queue can accept.
- cdb_valid  out  1  broadcast valid.
- cdb_rob_id  out  ROB_ID_W  broadcast tag.
- cdb_result  out  DATA_LEN  broadcast value.
- cdb_src  out  1  0 = ALU, 1 = LS (for ROB debug/commit stats).

Behaviour:
- Reset:
  - All queues empty.
  - cdb_valid=0, cdb_rob_id=0, cdb_result=0, cdb_src=0.
  - alu_ready=1, ls_ready=1.
  - last_grant=LS, so the ALU wins the first tie.
- Enqueue:
  - At posedge, source X enqueues when X_valid=1 and X_rob_id!=0.
  - An input with rob_id==0 is ignored.
  - X_ready = (count_X < DEPTH), computed from registered count only (no same-cycle dequeue credit).
  - X_valid while X_ready=0 is a protocol error; the input is dropped and queue state is unchanged.
- Dequeue/grant, evaluated on registered queue state each cycle:
  - Neither queue non-empty: cdb_valid<=0; other cdb outputs hold their last value.
  - Exactly one queue non-empty: grant it.
  - Both queues non-empty: grant the source != last_grant, then update last_grant.
  - On grant: the head entry is popped and registered into cdb_*, with cdb_valid<=1 for exactly that cycle.
- Latency: a result enqueued at edge N appears on the CDB after edge N+1 at the earliest (2-cycle input-to-broadcast).
- Throughput: 1 broadcast/cycle total. Each source is guaranteed at least every other cycle under contention.
- Simultaneous enqueue+dequeue on one queue: count unchanged, FIFO order preserved.
- Pointer wrap: read/write pointers of log2(DEPTH) bits wrap modulo DEPTH. count has log2(DEPTH)+1 bits.
- Flush:
  - At posedge with flush=1, both queues are emptied and cdb_valid<=0.
  - Inputs in the flush cycle are dropped.
  - last_grant is retained.
  - Flush takes priority over enqueue and grant.
- rst has priority over flush.
- Order: within a source, results broadcast in arrival order. Across sources there is no ordering guarantee.

Optional Feature:
- CDB_BYPASS_EN defined:
  - When source X's queue is empty, X_valid=1 with a nonzero tag, and X would win arbitration this cycle, the input is written directly into cdb_* at edge N (1-cycle latency), bypassing the queue.
  - For arbitration, the bypass candidate counts as a non-empty source; round-robin applies unchanged.
  - A losing bypass candidate is enqueued normally.
- Undefined: no bypass; fixed 2-cycle minimum latency.

Decomposition:
- Shared defines file: DATA_LEN, ROB_LEN, ZERO_ROB, ZERO_WORD, TRUE/FALSE, and an SRC_ALU/SRC_LS encoding.
- Sub-module cdb_fifo (DEPTH x {rob_id, result}), instantiated twice:
  - inputs push, pop, flush.
  - outputs head, empty, full/ready.
- The arbiter, last_grant and output register live in cdb_arbiter.

Test Plan:
- Single ALU result: alu_valid=1, tag 3, value 0x55 at edge 1 -> cdb_valid=1, tag 3, 0x55, src=0 after edge 2; cdb_valid=0 after edge 3.
- Contention: ALU tag 1 and LS tag 2 enqueued same edge (fresh reset) -> tag 1 broadcast first, then tag 2 next cycle. A repeat pair then grants LS first.
- Backpressure: hold ls_valid for DEPTH+1 consecutive cycles while ALU also streams -> ls_ready=0 after 2 enqueues. With DEPTH=2, LS results appear in order and none are lost when the producer honours ready.
- Zero tag: alu_valid=1 with tag 0 -> no enqueue, cdb_valid stays 0, alu_ready stays 1.
- Flush: 2 ALU and 1 LS results queued, flush=1 with a new LS input same cycle -> cdb_valid=0 next cycle, both ready=1, nothing broadcast afterward.
- CDB_BYPASS_EN: idle queues, LS tag 7, value 0xABCD at edge N -> cdb_valid=1, tag 7 after edge N (1 cycle). Without the macro -> after edge N+1.
